// File: rtl/gpr_commit_tracer.sv
// Architectural-state tracer at the commit point: shadow GPR file plus a
// first-word-fall-through trace FIFO of committed instructions with drop accounting.
module gpr_commit_tracer #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_inst,
  input  logic            commit_wen,
  input  logic [AW-1:0]   commit_rd,
  input  logic [XLEN-1:0] commit_wdata,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_wen,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_wdata,
  output logic [31:0]     out_seq,
  output logic            overflow,
  output logic [15:0]     drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] shadow [NREG];

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     inst_mem  [DEPTH];
  logic [AW-1:0]   rd_mem    [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];
  logic [31:0]     seq_mem   [DEPTH];
  logic [DEPTH-1:0] wen_mem;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   seq;

  logic wen_eff, full, pop, push, drop;

  // Handshake: a record transfers on any cycle where out_valid & out_ready;
  // out_valid never depends on out_ready and head fields hold until the transfer.
  assign wen_eff   = commit_wen & (commit_rd != '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = commit_valid & ~clr & (~full | pop);
  assign drop      = commit_valid & ~clr & full & ~pop;

  assign rd_data = (rd_idx == '0) ? '0 : shadow[rd_idx];

  // Empty FIFO presents zeros so the head fields have a defined reset value.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr]  : '0;
  assign out_wen   = out_valid ? wen_mem[rd_ptr]   : 1'b0;
  assign out_rd    = out_valid ? rd_mem[rd_ptr]    : '0;
  assign out_wdata = out_valid ? wdata_mem[rd_ptr] : '0;
  assign out_seq   = out_valid ? seq_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (commit_valid && wen_eff) begin
      shadow[commit_rd] <= commit_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= commit_pc;
      inst_mem[wr_ptr]  <= commit_inst;
      wen_mem[wr_ptr]   <= wen_eff;
      rd_mem[wr_ptr]    <= commit_rd;
      wdata_mem[wr_ptr] <= commit_wdata;
      seq_mem[wr_ptr]   <= seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Sequence advances on every commit, even dropped or flushed ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            seq <= '0;
    else if (commit_valid) seq <= seq + 32'd1;
  end

endmodule

// File: tb/tb_gpr_commit_tracer.sv
// Bench for gpr_commit_tracer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gpr_commit_tracer;

  localparam int W = 64 + 32 + 1 + 5 + 64 + 32;

  logic        clk, rst_n, clr;
  logic        commit_valid, commit_wen, out_ready;
  logic [63:0] commit_pc, commit_wdata;
  logic [31:0] commit_inst;
  logic [4:0]  commit_rd, rd_idx;
  logic [63:0] rd_data, out_pc, out_wdata;
  logic [31:0] out_inst, out_seq;
  logic        out_valid, out_wen, overflow;
  logic [4:0]  out_rd;
  logic [15:0] drop_cnt;

  gpr_commit_tracer #(.XLEN(64), .NREG(32), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen), .out_rd(out_rd),
    .out_wdata(out_wdata), .out_seq(out_seq),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [63:0]  m_regs [32];
  logic [31:0]  m_seq;
  logic         m_ovf;
  int           m_drop;
  int           n_checks, n_pass;
  bit           chk_en;
  logic [W-1:0] head;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_seq  = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Next state from the rules: flush wins, pop frees a slot, full means drop.
  task automatic model_step();
    bit popped;
    if (!rst_n) begin
      model_reset();
      return;
    end
    popped = (exp_q.size() > 0) && out_ready;
    if (clr) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (commit_valid) begin
        if (exp_q.size() < 8)
          exp_q.push_back({commit_pc, commit_inst, commit_wen && (commit_rd != 0),
                           commit_rd, commit_wdata, m_seq});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    if (commit_valid && commit_wen && commit_rd != 0) m_regs[commit_rd] = commit_wdata;
    if (commit_valid) m_seq = m_seq + 32'd1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("out_pc",    out_pc,    head[197:134]);
        chk("out_inst",  out_inst,  head[133:102]);
        chk("out_wen",   out_wen,   head[101]);
        chk("out_rd",    out_rd,    head[100:96]);
        chk("out_wdata", out_wdata, head[95:32]);
        chk("out_seq",   out_seq,   head[31:0]);
      end
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop[15:0]);
      chk("rd_data",  rd_data,  m_regs[rd_idx]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_valid = 1'b0; commit_wen = 1'b0; commit_rd = '0;
    commit_pc = '0; commit_inst = '0; commit_wdata = '0; clr = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                        input logic [63:0] wd);
    commit_valid = 1'b1; commit_pc = pc; commit_inst = pc[31:0] ^ 32'h0000_0013;
    commit_wen = wen; commit_rd = rd; commit_wdata = wd;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    n_checks = 0; n_pass = 0; chk_en = 1'b0;
    rst_n = 1'b0; out_ready = 1'b0; rd_idx = '0;
    idle();
    model_reset();
    chk_en = 1'b1;
    repeat (2) cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_seq", out_seq, 32'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;

    // Basic write and x0 write
    commit(64'h8000_0000, 1'b1, 5'd5, 64'hDEAD_BEEF);
    cyc();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_seq0", out_seq, 32'd0);
    chk("t1_wen0", out_wen, 1'b1);
    chk("t1_pc0", out_pc, 64'h8000_0000);
    commit(64'h8000_0004, 1'b1, 5'd0, 64'h1234);
    rd_idx = 5'd5;
    cyc();
    chk("t1_rd5", rd_data, 64'hDEAD_BEEF);
    idle();
    rd_idx = 5'd0;
    #1;
    chk("t1_rd0", rd_data, 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("t1_seq1", out_seq, 32'd1);
    chk("t1_wen1", out_wen, 1'b0);
    cyc();
    chk("t1_empty", out_valid, 1'b0);

    // Overflow: 10 commits with no consumer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      commit(64'h1000 + 64'(i * 4), 1'b1, 5'(i + 1), 64'(i));
      cyc();
    end
    idle();
    chk("t2_overflow", overflow, 1'b1);
    chk("t2_drop_cnt", drop_cnt, 16'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_seq", out_seq, 32'(i));
      cyc();
    end
    chk("t2_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    commit(64'h2000, 1'b0, 5'd0, 64'd0);
    cyc();
    idle();
    chk("t2_next_seq", out_seq, 32'd10);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      commit(64'h3000 + 64'(i * 4), 1'b1, 5'd9, 64'(i));
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      commit(64'h4000 + 64'(i * 4), 1'b1, 5'd10, 64'(i));
      chk("t3_seq", out_seq, 32'(i));
      cyc();
    end
    idle();
    chk("t3_no_drop", drop_cnt, 16'd0);
    chk("t3_no_ovf", overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_tail_seq", out_seq, 32'(20 + i));
      cyc();
    end
    chk("t3_count8", out_valid, 1'b0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      commit_valid = 1'($urandom_range(0, 1));
      commit_pc    = {$urandom, $urandom};
      commit_inst  = $urandom;
      commit_wen   = 1'($urandom_range(0, 1));
      commit_rd    = 5'($urandom_range(0, 31));
      commit_wdata = {$urandom, $urandom};
      clr          = ($urandom_range(0, 63) == 0);
      out_ready    = 1'($urandom_range(0, 1));
      rd_idx       = 5'($urandom_range(0, 31));
      cyc();
    end
    idle();

    // Flush with queued records and a same-cycle commit
    do_reset();
    for (int i = 0; i < 10; i++) begin
      commit(64'h5000 + 64'(i * 4), 1'b1, 5'd3, 64'(i));
      cyc();
    end
    idle();
    out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    chk("t5_pre_ovf", overflow, 1'b1);
    chk("t5_pre_seq", out_seq, 32'd4);
    commit(64'h6000, 1'b1, 5'd7, 64'h77);
    clr = 1'b1;
    cyc();
    idle();
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_drop", drop_cnt, 16'd0);
    rd_idx = 5'd7;
    #1;
    chk("t5_shadow", rd_data, 64'h77);
    commit(64'h6004, 1'b0, 5'd0, 64'd0);
    cyc();
    idle();
    chk("t5_next_seq", out_seq, 32'd11);

    // Asynchronous reset mid-burst
    do_reset();
    rd_idx = 5'd3;
    commit(64'h7000, 1'b1, 5'd3, 64'hABC);
    cyc();
    for (int i = 0; i < 10; i++) begin
      commit(64'h7004 + 64'(i * 4), 1'b1, 5'd4, 64'(i));
      cyc();
    end
    chk("t6_pre_ovf", overflow, 1'b1);
    chk("t6_pre_rd", rd_data, 64'hABC);
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_ovf", overflow, 1'b0);
    chk("t6_async_rd", rd_data, 64'd0);
    idle();
    cyc();
    rst_n = 1'b1;
    commit(64'h7100, 1'b1, 5'd2, 64'h5);
    cyc();
    idle();
    chk("t6_first_seq", out_seq, 32'd0);
    chk("t6_first_valid", out_valid, 1'b1);
    cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
